// File: rtl/aead_pkg.sv
// Shared types and widths for the AEAD stream packer and its word accumulator.
package aead_pkg;

   localparam int unsigned WORDS_PER_BLK = 16;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned BLK_W         = 512;
   localparam int unsigned KEY_W         = 256;
   localparam int unsigned NONCE_W       = 96;
   localparam int unsigned IDX_W         = $clog2(WORDS_PER_BLK);

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StFill,
      StIssue,
      StWait,
      StFinal
   } state_e;

endpackage

// File: rtl/aead_word_accum.sv
// Sixteen-word block accumulator: word k lands at data[BLK_W-1-WORD_W*k -: WORD_W].
module aead_word_accum
   import aead_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   output logic              full,
   output logic [BLK_W-1:0]  data
);

   logic [IDX_W-1:0] idx_q;
   logic [BLK_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q  <= '0;
         data_q <= '0;
      end else if (clear) begin
         idx_q  <= '0;
         data_q <= '0;
      end else if (wr_en) begin
         idx_q <= idx_q + 1'b1;
         for (int k = 0; k < WORDS_PER_BLK; k++) begin
            if (idx_q == IDX_W'(k)) begin
               data_q[BLK_W-1-WORD_W*k -: WORD_W] <= wr_data;
            end
         end
      end
   end

   // High while the next write completes the block.
   assign full = (idx_q == IDX_W'(WORDS_PER_BLK - 1));
   assign data = data_q;

endmodule

// File: rtl/aead_stream_packer.sv
// Packs a 32-bit word stream into 512-bit blocks and sequences the cipher core.
// Optional ready-timeout watchdog enabled by defining PACKER_TIMEOUT_EN.
module aead_stream_packer
   import aead_pkg::*;
#(
   parameter int unsigned READY_TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KEY_W-1:0]   cfg_key,
   input  logic [NONCE_W-1:0] cfg_nonce,
   input  logic               cfg_encdec,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WORD_W-1:0]  s_data,
   input  logic               s_last,
   output logic               core_init,
   output logic               core_next,
   output logic               core_done,
   output logic               core_encdec,
   output logic [KEY_W-1:0]   core_key,
   output logic [NONCE_W-1:0] core_nonce,
   output logic [BLK_W-1:0]   core_data,
   input  logic               core_ready,
   output logic               busy,
   output logic [15:0]        blk_count,
   output logic               err_timeout
);

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   key_q;
   logic [NONCE_W-1:0] nonce_q;
   logic               encdec_q;
   logic [15:0]        blk_count_q;
   logic               last_q;
   logic               skip_q;
   logic               acc_clear, acc_wr, acc_full;
   logic               start_acc;
   logic               timeout_hit;

   assign start_acc = (state_q == StIdle) && start;

   aead_word_accum u_accum (
      .clk     (clk),
      .rst     (rst),
      .clear   (acc_clear),
      .wr_en   (acc_wr),
      .wr_data (s_data),
      .full    (acc_full),
      .data    (core_data)
   );

   always_comb begin
      state_d   = state_q;
      core_init = 1'b0;
      core_next = 1'b0;
      core_done = 1'b0;
      acc_clear = 1'b0;
      acc_wr    = 1'b0;
      s_ready   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               acc_clear = 1'b1;
               state_d   = StInit;
            end
         end
         StInit: begin
            if (core_ready) begin
               core_init = 1'b1;
               state_d   = StFill;
            end
         end
         StFill: begin
            s_ready = 1'b1;
            if (s_valid) begin
               acc_wr = 1'b1;
               if (s_last || acc_full) state_d = StIssue;
            end
         end
         StIssue: begin
            if (core_ready) begin
               core_next = 1'b1;
               state_d   = StWait;
            end
         end
         StWait: begin
            // First WAIT cycle is skipped so the core can drop ready after core_next.
            if (!skip_q && core_ready) begin
               if (last_q) begin
                  state_d = StFinal;
               end else begin
                  acc_clear = 1'b1;
                  state_d   = StFill;
               end
            end
         end
         StFinal: begin
            core_done = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (timeout_hit) state_d = StIdle;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         key_q       <= '0;
         nonce_q     <= '0;
         encdec_q    <= 1'b0;
         blk_count_q <= '0;
         last_q      <= 1'b0;
         skip_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= core_next;
         if (start_acc) begin
            key_q       <= cfg_key;
            nonce_q     <= cfg_nonce;
            encdec_q    <= cfg_encdec;
            blk_count_q <= '0;
            last_q      <= 1'b0;
         end else begin
            if (core_next && (blk_count_q != 16'hFFFF)) blk_count_q <= blk_count_q + 16'd1;
            if (acc_wr && s_last) last_q <= 1'b1;
         end
      end
   end

`ifdef PACKER_TIMEOUT_EN
   localparam int unsigned TW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

   logic [TW-1:0] timer_q;
   logic          err_q;
   logic          stalled;

   assign stalled     = (state_q inside {StInit, StIssue, StWait}) && !core_ready;
   assign timeout_hit = stalled && (timer_q == TW'(READY_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         timer_q <= (stalled && !timeout_hit) ? timer_q + 1'b1 : '0;
         if (start_acc) err_q <= 1'b0;
         else if (timeout_hit) err_q <= 1'b1;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign busy        = (state_q != StIdle);
   assign blk_count   = blk_count_q;
   assign core_key    = key_q;
   assign core_nonce  = nonce_q;
   assign core_encdec = encdec_q;

endmodule

// File: tb/tb_aead_stream_packer.sv
// Directed + randomized bench for aead_stream_packer with a block-level reference model.
module tb_aead_stream_packer;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [255:0] cfg_key = '0;
   logic [95:0]  cfg_nonce = '0;
   logic         cfg_encdec = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         s_last = 1'b0;
   logic         core_init, core_next, core_done, core_encdec;
   logic [255:0] core_key;
   logic [95:0]  core_nonce;
   logic [511:0] core_data;
   logic         core_ready = 1'b1;
   logic         busy;
   logic [15:0]  blk_count;
   logic         err_timeout;

   int errors = 0;
   int checks = 0;
   int init_cnt = 0, next_cnt = 0, done_cnt = 0;
   int ready_mode = 0;
   int since_next = 1000;
   logic pi = 1'b0, pn = 1'b0, pd = 1'b0;
   logic [511:0] blocks[$];
   logic [31:0]  msg[$];

   aead_stream_packer #(.READY_TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_key     (cfg_key),
      .cfg_nonce   (cfg_nonce),
      .cfg_encdec  (cfg_encdec),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .core_init   (core_init),
      .core_next   (core_next),
      .core_done   (core_done),
      .core_encdec (core_encdec),
      .core_key    (core_key),
      .core_nonce  (core_nonce),
      .core_data   (core_data),
      .core_ready  (core_ready),
      .busy        (busy),
      .blk_count   (blk_count),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Core-ready behaviour: 0 always ready, 1 low for 5 cycles after each next,
   // 2 never ready, otherwise random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       core_ready = 1'b1;
         1:       core_ready = !(since_next >= 1 && since_next <= 5);
         2:       core_ready = 1'b0;
         default: core_ready = 1'($urandom_range(1));
      endcase
   end

   // Pulse monitor: pulses are mutually exclusive and never last two cycles.
   always @(negedge clk) begin
      if (core_init || core_next || core_done) begin
         check("pulse_exclusive",
               {509'd0, core_init && !pi, core_next && !pn, core_done && !pd},
               {509'd0, core_init, core_next, core_done} &
               {509'd0, {3{$countones({core_init, core_next, core_done}) == 1}}});
      end
      pi = core_init; pn = core_next; pd = core_done;
      if (core_init) init_cnt++;
      if (core_done) done_cnt++;
      if (core_next) begin
         next_cnt++;
         blocks.push_back(core_data);
         since_next = 0;
      end else if (since_next < 1000) begin
         since_next++;
      end
   end

   // Reference: block b holds message words 16b..16b+15, absent words zero.
   function automatic logic [511:0] exp_block(input int b, input int n);
      logic [511:0] v = '0;
      for (int w = 0; w < 16; w++)
         if (16 * b + w < n) v[511-32*w -: 32] = msg[16*b+w];
      return v;
   endfunction

   task automatic do_start(input logic [255:0] k, input logic [95:0] nn, input logic ed);
      @(posedge clk); #1;
      cfg_key = k; cfg_nonce = nn; cfg_encdec = ed; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_msg(input int n, input int pct, input bit with_last);
      int i = 0;
      int cyc = 0;
      bit hs;
      while (i < n && cyc < 20000) begin
         s_valid = ($urandom_range(99) < pct);
         s_data  = msg[i];
         s_last  = with_last && (i == n - 1);
         @(negedge clk);
         hs = s_valid && s_ready;
         @(posedge clk); #1;
         if (hs) i++;
         cyc++;
      end
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      check("send_words", i, n);
   endtask

   task automatic wait_done(input int prev);
      int cyc = 0;
      while (done_cnt == prev && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      check("done_seen", done_cnt, prev + 1);
   endtask

   task automatic run_msg(input string tag, input int n, input int pct, input logic [255:0] k,
                          input logic [95:0] nn, input logic ed, input bit poke_start);
      int nb = (n + 15) / 16;
      init_cnt = 0; next_cnt = 0; done_cnt = 0;
      blocks.delete();
      do_start(k, nn, ed);
      if (poke_start) do_start(~k, ~nn, ~ed);
      send_msg(n, pct, 1'b1);
      wait_done(0);
      check({tag, "_init"}, init_cnt, 1);
      check({tag, "_next"}, next_cnt, nb);
      for (int b = 0; b < nb; b++)
         if (b < blocks.size()) check($sformatf("%s_blk%0d", tag, b), blocks[b], exp_block(b, n));
      check({tag, "_blk_count"}, blk_count, nb);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_key"}, core_key, k);
      check({tag, "_nonce"}, core_nonce, nn);
      check({tag, "_encdec"}, core_encdec, ed);
      check({tag, "_err"}, err_timeout, 0);
   endtask

   initial begin
      logic [255:0] k;
      logic [95:0]  nn;
      int           n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_data", core_data, 0);
      check("rst_key", core_key, 0);
      check("rst_blk_count", blk_count, 0);
      check("rst_pulses", {core_init, core_next, core_done}, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Full single block, alternating pattern.
      msg.delete();
      for (int i = 0; i < 16; i++) msg.push_back((i % 2 == 0) ? 32'hcafebabe : 32'hdeadbeef);
      run_msg("full16", 16, 100, {4{64'h0123456789abcdef}}, 96'h11111111_22222222_33333333,
              1'b1, 1'b0);
      check("full16_literal", blocks.size() > 0 ? blocks[0] : '0,
            {4{128'hcafebabedeadbeefcafebabedeadbeef}});

      // Short message padded with zeros.
      msg.delete();
      for (int i = 1; i <= 3; i++) msg.push_back(32'hA0000000 + 32'(i));
      run_msg("short3", 3, 100, {8{32'h5a5a0001}}, 96'h1, 1'b0, 1'b0);
      check("short3_literal", blocks.size() > 0 ? blocks[0] : '0,
            {32'hA0000001, 32'hA0000002, 32'hA0000003, 416'd0});

      // 40 words with core_ready dropping after each block issue.
      ready_mode = 1;
      msg.delete();
      for (int i = 0; i < 40; i++) msg.push_back($urandom);
      run_msg("w40", 40, 100, {8{$urandom}}, {3{$urandom}}, 1'b1, 1'b0);

      // Randomized lengths, valid gaps, ready jitter, and a start pulse while busy.
      ready_mode = 3;
      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(50, 1);
         msg.delete();
         for (int i = 0; i < n; i++) msg.push_back($urandom);
         k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         nn = {$urandom, $urandom, $urandom};
         run_msg($sformatf("rnd%0d", t), n, 70, k, nn, 1'($urandom_range(1)), t[0]);
      end

      // Reset in the middle of block 2.
      ready_mode = 0;
      msg.delete();
      for (int i = 0; i < 40; i++) msg.push_back($urandom);
      init_cnt = 0; next_cnt = 0; done_cnt = 0;
      do_start({8{32'h77777777}}, 96'h3, 1'b1);
      send_msg(23, 100, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_busy", busy, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_data", core_data, 0);
      check("midrst_cfg", {core_key, core_nonce, core_encdec}, 0);
      check("midrst_blk_count", blk_count, 0);
      check("midrst_pulses", {core_init, core_next, core_done}, 0);
      @(negedge clk);
      check("midrst_no_done", done_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_msg("after_rst", 20, 100, {8{32'h13572468}}, 96'h4, 1'b0, 1'b0);

`ifdef PACKER_TIMEOUT_EN
      init_cnt = 0; next_cnt = 0; done_cnt = 0;
      msg.delete();
      for (int i = 0; i < 3; i++) msg.push_back($urandom);
      do_start({8{32'h0f0f0f0f}}, 96'h5, 1'b1);
      @(posedge clk); #1;
      ready_mode = 2;
      send_msg(3, 100, 1'b1);
      repeat (30) @(negedge clk);
      check("tmo_err", err_timeout, 1);
      check("tmo_busy", busy, 0);
      check("tmo_next", next_cnt, 0);
      check("tmo_done", done_cnt, 0);
      ready_mode = 0;
      run_msg("tmo_recover", 5, 100, {8{32'h2468ace0}}, 96'h6, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
